// File: rtl/activity_led.sv
// rtl/activity_led.sv - activity LED pulse stretcher (ON/OFF flash); optional event counter under ACTIVITY_COUNT_EN
module activity_led #(
  parameter int ON_CYCLES      = 4000000,
  parameter int OFF_CYCLES     = 4000000,
  parameter bit LED_ACTIVE_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trigger,
  input  logic        count_clr,
  output logic        led,
  output logic        busy,
  output logic [15:0] event_count
);

  // One counter serves both phases, so it is sized for the longer one.
  localparam int MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Pin levels for a lit and a dark LED.
  localparam logic LED_LIT  = 1'b1 ^ LED_ACTIVE_LOW;
  localparam logic LED_DARK = 1'b0 ^ LED_ACTIVE_LOW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             pending;

  // Flash sequencer: every flash is a full ON phase followed by a full OFF gap; triggers seen meanwhile chain one more flash.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      pending <= 1'b0;
      led     <= LED_DARK;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            state <= ON;
            count <= ON_LOAD;
            led   <= LED_LIT;
            busy  <= 1'b1;
          end else begin
            led   <= LED_DARK;
            busy  <= 1'b0;
          end
        end

        ON: begin
          busy <= 1'b1;
          if (trigger) begin
            pending <= 1'b1;
          end
          if (count == '0) begin
            state <= OFF;
            count <= OFF_LOAD;
            led   <= LED_DARK;
          end else begin
            count <= count - CNT_ONE;
            led   <= LED_LIT;
          end
        end

        OFF: begin
          if (count == '0) begin
            // A trigger on the final dark cycle counts just like an earlier one.
            if (pending || trigger) begin
              state   <= ON;
              count   <= ON_LOAD;
              pending <= 1'b0;
              led     <= LED_LIT;
              busy    <= 1'b1;
            end else begin
              state   <= IDLE;
              led     <= LED_DARK;
              busy    <= 1'b0;
            end
          end else begin
            count <= count - CNT_ONE;
            led   <= LED_DARK;
            busy  <= 1'b1;
            if (trigger) begin
              pending <= 1'b1;
            end
          end
        end

        default: begin
          state   <= IDLE;
          count   <= '0;
          pending <= 1'b0;
          led     <= LED_DARK;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef ACTIVITY_COUNT_EN
  // Saturating tally of trigger-high cycles; a clear on the same edge as a trigger wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      event_count <= 16'h0000;
    end else if (count_clr) begin
      event_count <= 16'h0000;
    end else if (trigger && (event_count != 16'hFFFF)) begin
      event_count <= event_count + 16'h0001;
    end
  end
`else
  // Counter not built: report zero and leave count_clr without effect.
  logic unused_count_clr;
  assign unused_count_clr = count_clr;
  assign event_count      = 16'h0000;
`endif

endmodule

// File: tb/tb_activity_led.sv
// tb/tb_activity_led.sv - directed self-checking bench for activity_led (ON=4, OFF=3)
module tb_activity_led;

`ifdef ACTIVITY_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        trigger;
  logic        count_clr;
  logic        led;
  logic        busy;
  logic [15:0] event_count;
  logic        led_n;
  logic        busy_n;
  logic [15:0] event_count_n;

  int tests_run;
  int tests_failed;

  activity_led #(
    .ON_CYCLES      (4),
    .OFF_CYCLES     (3),
    .LED_ACTIVE_LOW (1'b0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .trigger     (trigger),
    .count_clr   (count_clr),
    .led         (led),
    .busy        (busy),
    .event_count (event_count)
  );

  activity_led #(
    .ON_CYCLES      (4),
    .OFF_CYCLES     (3),
    .LED_ACTIVE_LOW (1'b1)
  ) dut_n (
    .clk         (clk),
    .rst_n       (rst_n),
    .trigger     (trigger),
    .count_clr   (count_clr),
    .led         (led_n),
    .busy        (busy_n),
    .event_count (event_count_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    trigger   = 1'b0;
    count_clr = 1'b0;
    repeat (20) step();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    trigger   = 1'b0;
    count_clr = 1'b0;
    repeat (5) step();
    tests_run++;
    if (led !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_led: got %b expected 0", led);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
    tests_run++;
    if (event_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_event_count: got %0d expected 0", event_count);
    end
    tests_run++;
    if (led_n !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_led_active_low: got %b expected 1", led_n);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_pulse();
    logic exp_led;
    logic exp_busy;
    trigger = 1'b1;
    tests_run++;
    if (led !== 1'b0) begin
      tests_failed++;
      $display("FAIL pulse_no_comb_path: got %b expected 0", led);
    end
    step();
    trigger = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      exp_led  = (i <= 4);
      exp_busy = (i <= 7);
      tests_run++;
      if (led !== exp_led || busy !== exp_busy || led_n !== ~exp_led) begin
        tests_failed++;
        $display("FAIL pulse_edge%0d: got led=%b busy=%b led_n=%b expected led=%b busy=%b led_n=%b",
                 i, led, busy, led_n, exp_led, exp_busy, ~exp_led);
      end
      if (i < 8) step();
    end
  endtask

  task automatic test_continuous();
    logic exp_led;
    trigger = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      exp_led = (((k - 1) % 7) < 4);
      tests_run++;
      if (led !== exp_led || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL continuous_edge%0d: got led=%b busy=%b expected led=%b busy=1",
                 k, led, busy, exp_led);
      end
    end
    trigger = 1'b0;
    repeat (20) step();
    tests_run++;
    if (busy !== 1'b0 || led !== 1'b0) begin
      tests_failed++;
      $display("FAIL continuous_drain: got led=%b busy=%b expected led=0 busy=0", led, busy);
    end
  endtask

  task automatic test_trigger_in_off();
    logic exp_led;
    logic exp_busy;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      exp_led  = (i <= 4) || (i >= 8 && i <= 11);
      exp_busy = (i <= 14);
      tests_run++;
      if (led !== exp_led || busy !== exp_busy) begin
        tests_failed++;
        $display("FAIL off_retrigger_edge%0d: got led=%b busy=%b expected led=%b busy=%b",
                 i, led, busy, exp_led, exp_busy);
      end
      trigger = (i + 1 == 7);
      if (i < 15) step();
    end
    trigger = 1'b0;
  endtask

  task automatic test_async_reset();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    step();
    tests_run++;
    if (led !== 1'b1) begin
      tests_failed++;
      $display("FAIL async_pre_led: got %b expected 1", led);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (led !== 1'b0 || busy !== 1'b0 || led_n !== 1'b1) begin
      tests_failed++;
      $display("FAIL async_immediate: got led=%b busy=%b led_n=%b expected led=0 busy=0 led_n=1",
               led, busy, led_n);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    tests_run++;
    if (led !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_idle_after_release: got led=%b busy=%b expected 0 0", led, busy);
    end
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tests_run++;
      if (led !== (i <= 4)) begin
        tests_failed++;
        $display("FAIL async_restart_edge%0d: got led=%b expected %b", i, led, (i <= 4));
      end
      if (i < 5) step();
    end
    settle();
  endtask

  task automatic test_event_count();
    logic [15:0] exp_cnt;
    count_clr = 1'b1;
    trigger   = 1'b0;
    step();
    count_clr = 1'b0;
    tests_run++;
    if (event_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL count_clear: got %0d expected 0", event_count);
    end

    trigger = 1'b1;
    repeat (10) step();
    trigger = 1'b0;
    step();
    exp_cnt = CNT_EN ? 16'd10 : 16'd0;
    tests_run++;
    if (event_count !== exp_cnt) begin
      tests_failed++;
      $display("FAIL count_ten: got %0d expected %0d", event_count, exp_cnt);
    end

    count_clr = 1'b1;
    step();
    count_clr = 1'b0;
    trigger   = 1'b1;
    repeat (65540) step();
    trigger = 1'b0;
    step();
    exp_cnt = CNT_EN ? 16'hFFFF : 16'd0;
    tests_run++;
    if (event_count !== exp_cnt) begin
      tests_failed++;
      $display("FAIL count_saturate: got %0d expected %0d", event_count, exp_cnt);
    end
    step();
    tests_run++;
    if (event_count !== exp_cnt) begin
      tests_failed++;
      $display("FAIL count_hold: got %0d expected %0d", event_count, exp_cnt);
    end

    trigger   = 1'b1;
    count_clr = 1'b1;
    step();
    count_clr = 1'b0;
    tests_run++;
    if (event_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL count_clear_wins: got %0d expected 0", event_count);
    end
    step();
    trigger = 1'b0;
    exp_cnt = CNT_EN ? 16'd1 : 16'd0;
    tests_run++;
    if (event_count !== exp_cnt) begin
      tests_failed++;
      $display("FAIL count_after_clear: got %0d expected %0d", event_count, exp_cnt);
    end
    settle();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    trigger      = 1'b0;
    count_clr    = 1'b0;
    test_reset();
    test_single_pulse();
    settle();
    test_continuous();
    settle();
    test_trigger_in_off();
    settle();
    test_async_reset();
    test_event_count();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
